bitfusion_feeder: RTL and testbench
===================================

# bitfusion_feeder

Sequencer that drives the BitFusion systolic array from the control side. It performs the same duty the array bench performs by hand. On a start request it clears the row accumulators, then issues the skewed diagonal wavefront of `input_rd_en` / `weight_rd_en` for a programmed number of read steps per fusion unit. It holds the precision configuration stable throughout, waits for the array to drain, then captures `OBUF` and presents it on a valid/ready result port. It sits between the layer controller and the `bitfusion` array instance.

## Interface
- `ARRAY_SIZE`, 2, array rows/columns (N).
- `DATA_W`, 32, width of one OBUF word.
- `LEN_W`, 8, width of the per-FU read-step count.
- `DRAIN_LAT`, 4, cycles from the last feed cycle to a valid `OBUF` (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to run one tile; sampled only in IDLE.
- `len`  in  LEN_W  read steps per FU; 0 is illegal.
- `cfg_input_bitwidth`  in  3  precision code: 001=2b, 010=4b, 100=8b.
- `cfg_weight_bitwidth`  in  3  same encoding.
- `cfg_input_sign`  in  [N][N][4]  sign config, latched at start.
- `cfg_weight_sign`  in  [N][N][4]  sign config, latched at start.
- `input_rd_en`  out  [N]  to array.
- `weight_rd_en`  out  [N][N]  to array.
- `acc_clear`  out  [N]  to array.
- `input_bitwidth`, `weight_bitwidth`  out  3 each  latched config to array.
- `input_sign`, `weight_sign`  out  [N][N][4]  latched config to array.
- `OBUF`  in  [N][DATA_W]  array result.
- `res_valid`  out  1  `res_data` is valid.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  [N][DATA_W]  captured OBUF.
- `busy`  out  1  high in every state except IDLE.
- `cfg_err`  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE → CLEAR → FEED → DRAIN → OUT → IDLE.
- IDLE, `start`=1: the start is legal only if both bitwidth codes are one-hot among {001,010,100} and `len`≠0.
  - Legal: latch `len` and all cfg inputs, then go to CLEAR.
  - Illegal: pulse `cfg_err`, stay in IDLE, leave all latched values unchanged.
- CLEAR: one cycle, `acc_clear` = all ones.
- FEED: step counter t runs 0 … F−1, with F = len + 2(N−1).
  - Each FU[r][c] is active when r+c ≤ t < r+c+len.
  - `weight_rd_en[r][c]` = FU[r][c] active.
  - `input_rd_en[r]` = FU[r][0] active.
  - Leave FEED after t = F−1.
- DRAIN: counts DRAIN_LAT cycles. On the final DRAIN edge, `res_data` ← `OBUF`.
- OUT: `res_valid`=1 and `res_data` held stable until `res_valid & res_ready`, then return to IDLE. There is no timeout.
- Latched bitwidth and sign outputs are constant from CLEAR through OUT and retain their value in IDLE.
- `start` outside IDLE is ignored and does not set `cfg_err`.
- Counters are sized to hold F without overflow: LEN_W+1 bits plus log2(2N).

## Timing
- Reset (async, immediate): state = IDLE. These outputs are 0: all rd_en, `acc_clear`, `res_valid`, `busy`, `cfg_err`, `res_data`, bitwidth and sign outputs.
- Reset asserted mid-operation aborts the tile. After release, the block sits in IDLE with no residual enables.
- All outputs are registered; no input-to-output combinational path.
- Edge numbering: start sampled at edge E0.
  - CLEAR during cycle E0→E1.
  - FEED t=0 begins at E1.
  - The last enable deasserts at E1+F.
  - `res_data` is captured at edge E1+F+DRAIN_LAT.
  - `res_valid` is high from that edge on.
- Start-to-result latency: 2 + F + DRAIN_LAT − 1 cycles after the start edge. For N=2, len=2, DRAIN_LAT=4 this is 9.
- `res_ready` held high in OUT: handshake completes at the first OUT edge, and a new `start` is accepted on the following edge.

## Test plan
- Reset then idle: hold `RST` for 2 cycles with `start`=0 → all outputs 0, `busy`=0.
- Legal tile, N=2, len=2, codes 100/010:
  - `acc_clear`=11 for one cycle.
  - `weight_rd_en` per FEED cycle = {00:1}, {00,01,10}, {01,10,11}, {11}.
  - `input_rd_en` = 01, 11, 10, 00.
  - With `OBUF`=`{32'd5,32'd9}` during DRAIN, `res_data`=`{5,9}`.
  - `res_valid` high 4 cycles after the last enable.
- Backpressure: `res_ready`=0 for 6 cycles in OUT → `res_valid` and `res_data` stable, with `OBUF` changed to 0 meanwhile; then `res_ready`=1 → handshake completes and `busy`=0 the next cycle.
- Illegal config: `input_bitwidth`=011 with `start`, and separately `len`=0 with `start` → `cfg_err` pulses 1 cycle each, state stays IDLE, no enables.
- Mid-run reset: assert `RST` at FEED t=1 → all enables 0 immediately. After release, a fresh len=1 tile runs with F=3, enables {00}, {01,10}, {11}.
- Start while busy: pulse `start` during DRAIN → ignored, no `cfg_err`, result timing unchanged.

Source files
------------

// File: rtl/bitfusion_feeder.sv
// Control-side sequencer for the BitFusion array: clears accumulators, drives the
// skewed rd_en wavefront, waits out the drain latency and returns OBUF on a valid/ready port.
//
// state   | meaning
// S_IDLE  | waiting for start; config checked and latched here
// S_CLEAR | one cycle of acc_clear to every row
// S_FEED  | step counter walks 0..F-1 issuing the diagonal wavefront
// S_DRAIN | down-counter covers the array drain latency, OBUF captured at terminal count
// S_OUT   | result held on res_data until res_valid & res_ready
module bitfusion_feeder #(
  parameter int ARRAY_SIZE = 2,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int DRAIN_LAT  = 4
) (
  input  logic                                         clk,
  input  logic                                         RST,
  input  logic                                         start,
  input  logic [LEN_W-1:0]                             len,
  input  logic [2:0]                                   cfg_input_bitwidth,
  input  logic [2:0]                                   cfg_weight_bitwidth,
  input  logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][3:0]   cfg_input_sign,
  input  logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][3:0]   cfg_weight_sign,
  output logic [ARRAY_SIZE-1:0]                        input_rd_en,
  output logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0]        weight_rd_en,
  output logic [ARRAY_SIZE-1:0]                        acc_clear,
  output logic [2:0]                                   input_bitwidth,
  output logic [2:0]                                   weight_bitwidth,
  output logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][3:0]   input_sign,
  output logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][3:0]   weight_sign,
  input  logic [ARRAY_SIZE-1:0][DATA_W-1:0]            OBUF,
  output logic                                         res_valid,
  input  logic                                         res_ready,
  output logic [ARRAY_SIZE-1:0][DATA_W-1:0]            res_data,
  output logic                                         busy,
  output logic                                         cfg_err
);

  localparam int N     = ARRAY_SIZE;
  localparam int CNT_W = LEN_W + 1 + $clog2(2 * N);
  localparam int DR_W  = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
  localparam logic [CNT_W-1:0] SKEW    = CNT_W'(2 * (N - 1));
  localparam logic [DR_W-1:0]  DR_LOAD = DR_W'(DRAIN_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  step, step_nxt, step_last;
  logic [DR_W-1:0]   drain_cnt, drain_nxt;
  logic [LEN_W-1:0]  len_q;
  logic              start_ok;
  logic              cfg_ld;
  logic              reject;
  logic              capture;
  logic [N-1:0][N-1:0] wave_nxt;
  logic [N-1:0]        in_nxt;

  function automatic logic code_ok(input logic [2:0] code);
    return (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
  endfunction

  always_comb begin
    start_ok  = code_ok(cfg_input_bitwidth) && code_ok(cfg_weight_bitwidth) && (len != '0);
    state_nxt = state;
    step_nxt  = step;
    drain_nxt = drain_cnt;
    cfg_ld    = 1'b0;
    reject    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            cfg_ld    = 1'b1;
            state_nxt = S_CLEAR;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        state_nxt = S_FEED;
        step_nxt  = '0;
      end
      S_FEED: begin
        if (step == step_last) begin
          state_nxt = S_DRAIN;
          drain_nxt = DR_LOAD;
        end else begin
          step_nxt = step + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_OUT;
        end else begin
          drain_nxt = drain_cnt - DR_W'(1);
        end
      end
      S_OUT: begin
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Enables are registered, so they are decoded from the step value of the coming cycle.
  always_comb begin
    wave_nxt = '0;
    in_nxt   = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        wave_nxt[r][c] = (state_nxt == S_FEED) &&
                         (step_nxt >= CNT_W'(r + c)) &&
                         (step_nxt < CNT_W'(r + c) + CNT_W'(len_q));
      end
      in_nxt[r] = wave_nxt[r][0];
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      step      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      input_rd_en     <= '0;
      weight_rd_en    <= '0;
      acc_clear       <= '0;
      busy            <= 1'b0;
      cfg_err         <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      len_q           <= '0;
      step_last       <= '0;
      input_bitwidth  <= '0;
      weight_bitwidth <= '0;
      input_sign      <= '0;
      weight_sign     <= '0;
    end else begin
      input_rd_en  <= in_nxt;
      weight_rd_en <= wave_nxt;
      acc_clear    <= {N{state_nxt == S_CLEAR}};
      busy         <= (state_nxt != S_IDLE);
      cfg_err      <= reject;
      res_valid    <= (state_nxt == S_OUT);
      if (capture) res_data <= OBUF;
      if (cfg_ld) begin
        len_q           <= len;
        // len is nonzero here, so F-1 cannot underflow
        step_last       <= CNT_W'(len) + SKEW - CNT_W'(1);
        input_bitwidth  <= cfg_input_bitwidth;
        weight_bitwidth <= cfg_weight_bitwidth;
        input_sign      <= cfg_input_sign;
        weight_sign     <= cfg_weight_sign;
      end
    end
  end

endmodule

// File: tb/tb_bitfusion_feeder.sv
// Scoreboard bench for bitfusion_feeder: the driver plans per-cycle expectations and results,
// and an independent monitor compares every cycle and every presented result.
module tb_bitfusion_feeder;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int DL = 4;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [2:0] cib = '0, cwb = '0;
  logic [N-1:0][N-1:0][3:0] cis = '0, cws = '0;
  logic [N-1:0][DW-1:0] OBUF = '0;
  logic res_ready = 1'b1;

  logic [N-1:0] input_rd_en, acc_clear;
  logic [N-1:0][N-1:0] weight_rd_en;
  logic [2:0] input_bitwidth, weight_bitwidth;
  logic [N-1:0][N-1:0][3:0] input_sign, weight_sign;
  logic res_valid, busy, cfg_err;
  logic [N-1:0][DW-1:0] res_data;

  bitfusion_feeder #(.ARRAY_SIZE(N), .DATA_W(DW), .LEN_W(LW), .DRAIN_LAT(DL)) dut (
    .clk(clk), .RST(RST), .start(start), .len(len),
    .cfg_input_bitwidth(cib), .cfg_weight_bitwidth(cwb),
    .cfg_input_sign(cis), .cfg_weight_sign(cws),
    .input_rd_en(input_rd_en), .weight_rd_en(weight_rd_en), .acc_clear(acc_clear),
    .input_bitwidth(input_bitwidth), .weight_bitwidth(weight_bitwidth),
    .input_sign(input_sign), .weight_sign(weight_sign),
    .OBUF(OBUF), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic clr, err, bsy, ld;
    logic [N-1:0] in_en;
    logic [N-1:0][N-1:0] w_en;
    logic [2:0] ib, wb;
    logic [N-1:0][N-1:0][3:0] isg, wsg;
  } exp_t;

  typedef struct packed {
    logic [N-1:0][DW-1:0] data;
    int cap;
  } res_t;

  exp_t exp_map[int];
  res_t res_q[$];
  int checks = 0, failures = 0, hs_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t get_e(input int k);
    if (exp_map.exists(k)) return exp_map[k];
    return '0;
  endfunction

  function automatic logic [2:0] rand_code();
    case ($urandom_range(0, 2))
      0: return 3'b001;
      1: return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Monitor: samples 2 time units after the falling edge, after the driver has moved.
  initial begin
    exp_t e;
    logic [2:0] m_ib, m_wb;
    logic [N-1:0][N-1:0][3:0] m_is, m_ws;
    logic exp_busy, hs_prev, v_prev;
    m_ib = '0; m_wb = '0; m_is = '0; m_ws = '0;
    exp_busy = 0; hs_prev = 0; v_prev = 0;
    forever begin
      @(negedge clk);
      #2;
      if (RST) begin
        chk("reset_outputs", {input_rd_en, weight_rd_en, acc_clear, input_bitwidth, weight_bitwidth,
                              input_sign, weight_sign, res_valid, busy, cfg_err, res_data}, '0);
        m_ib = '0; m_wb = '0; m_is = '0; m_ws = '0;
        exp_busy = 0; hs_prev = 0; v_prev = 0;
      end else begin
        e = get_e(cyc);
        if (hs_prev) exp_busy = 0;
        if (e.bsy) exp_busy = 1;
        if (e.ld) begin
          m_ib = e.ib; m_wb = e.wb; m_is = e.isg; m_ws = e.wsg;
        end
        chk("acc_clear", acc_clear, {N{e.clr}});
        chk("input_rd_en", input_rd_en, e.in_en);
        chk("weight_rd_en", weight_rd_en, e.w_en);
        chk("cfg_err", cfg_err, e.err);
        chk("busy", busy, exp_busy);
        chk("cfg_out", {input_bitwidth, weight_bitwidth, input_sign, weight_sign},
            {m_ib, m_wb, m_is, m_ws});
        if (res_valid) begin
          if (res_q.size() == 0) begin
            chk("res_valid_spurious", res_valid, 1'b0);
          end else begin
            if (!v_prev) chk("res_valid_cycle", cyc, res_q[0].cap);
            chk("res_data", res_data, res_q[0].data);
            if (res_ready) begin
              void'(res_q.pop_front());
              hs_cnt++;
            end
          end
        end
        hs_prev = res_valid && res_ready;
        v_prev  = res_valid;
      end
    end
  end

  task automatic slot();
    @(negedge clk);
    #1;
  endtask

  task automatic scramble();
    len = LW'($urandom); cib = 3'($urandom); cwb = 3'($urandom);
    cis = 16'($urandom); cws = 16'($urandom);
  endtask

  // Plans the whole expected trace of one legal tile starting at the current slot.
  task automatic plan_tile(input int l, input logic [2:0] ib, input logic [2:0] wb,
                           input logic [N-1:0][DW-1:0] val, output int e0, output int cap);
    exp_t e;
    res_t rr;
    logic [N-1:0][N-1:0][3:0] isg, wsg;
    int f;
    isg = 16'($urandom); wsg = 16'($urandom);
    e0  = cyc + 1;
    f   = l + 2 * (N - 1);
    cap = e0 + 1 + f + DL;
    e = get_e(e0);
    e.clr = 1; e.bsy = 1; e.ld = 1; e.ib = ib; e.wb = wb; e.isg = isg; e.wsg = wsg;
    exp_map[e0] = e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        for (int k = 0; k < l; k++) begin
          e = get_e(e0 + 1 + r + c + k);
          e.w_en[r][c] = 1'b1;
          if (c == 0) e.in_en[r] = 1'b1;
          exp_map[e0 + 1 + r + c + k] = e;
        end
    rr.data = val; rr.cap = cap;
    res_q.push_back(rr);
    len = LW'(l); cib = ib; cwb = wb; cis = isg; cws = wsg; start = 1'b1;
  endtask

  task automatic run_tile(input int l, input logic [2:0] ib, input logic [2:0] wb,
                          input logic [N-1:0][DW-1:0] val, input int bp, input bit poke);
    int e0, cap, t0, k, f;
    f = l + 2 * (N - 1);
    t0 = hs_cnt;
    plan_tile(l, ib, wb, val, e0, cap);
    res_ready = (bp == 0);
    slot();
    start = 1'b0;
    scramble();
    while (cyc < cap - 1) begin
      if (poke && cyc == e0 + f + 2) begin
        start = 1'b1; len = '0;
      end else begin
        start = 1'b0;
      end
      OBUF = {$urandom, $urandom};
      slot();
    end
    start = 1'b0;
    OBUF = val;
    slot();
    OBUF = '0;
    if (bp > 0) begin
      repeat (bp) slot();
      res_ready = 1'b1;
    end
    k = 0;
    while (hs_cnt == t0 && k < 50) begin
      slot();
      k++;
    end
    if (hs_cnt == t0) chk("handshake_timeout", hs_cnt, t0 + 1);
    res_ready = 1'b1;
  endtask

  task automatic illegal(input int l, input logic [2:0] ib, input logic [2:0] wb);
    exp_t e;
    e = get_e(cyc + 1);
    e.err = 1;
    exp_map[cyc + 1] = e;
    len = LW'(l); cib = ib; cwb = wb; cis = 16'($urandom); cws = 16'($urandom);
    start = 1'b1;
    slot();
    start = 1'b0;
    scramble();
    repeat (2) slot();
  endtask

  task automatic mid_reset();
    int e0, cap;
    plan_tile(2, 3'b001, 3'b100, {$urandom, $urandom}, e0, cap);
    slot();
    start = 1'b0;
    while (cyc < e0 + 2) slot();
    RST = 1'b1;
    exp_map.delete();
    res_q.delete();
    #1;
    chk("rst_kills_enables", {input_rd_en, weight_rd_en, acc_clear, busy}, '0);
    repeat (2) slot();
    RST = 1'b0;
    slot();
    run_tile(1, 3'b010, 3'b010, {$urandom, $urandom}, 0, 0);
  endtask

  logic [2:0] bad_codes [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    repeat (2) @(posedge clk);
    slot();
    RST = 1'b0;
    slot();
    run_tile(2, 3'b100, 3'b010, {32'd5, 32'd9}, 0, 0);
    run_tile(2, 3'b100, 3'b010, {32'd7, 32'd11}, 6, 0);
    illegal(2, 3'b011, 3'b010);
    illegal(0, 3'b100, 3'b100);
    mid_reset();
    run_tile(2, 3'b010, 3'b001, {$urandom, $urandom}, 0, 1);
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0)
          illegal($urandom_range(1, 8), bad_codes[$urandom_range(0, 4)], rand_code());
        else
          illegal(0, rand_code(), rand_code());
      end else begin
        run_tile($urandom_range(1, 8), rand_code(), rand_code(), {$urandom, $urandom},
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end
    run_tile(255, 3'b100, 3'b100, {$urandom, $urandom}, 1, 0);
    repeat (3) slot();
    chk("res_queue_drained", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
